// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the M-extension multiply/divide unit.
// Op codes follow funct3; the FSM enum is shared with the divider.
package ex_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } md_state_e;

    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 6;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Execute-side request/response bundle of the mul/div unit.
// master: pipeline side; slave: the unit.
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            freeze;
    logic            flush;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, rs1, rs2,
        output freeze, flush,
        input  busy, valid, result
    );

    modport slave (
        input  start, op, rs1, rs2,
        input  freeze, flush,
        output busy, valid, result
    );
endinterface

// File: rtl/ex_muldiv_unit_divider.sv
// Restoring radix-2 divider on unsigned magnitudes.
// One quotient bit per step; done after DIV_ITERS steps.
module muldiv_divider
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem,
    output logic            done
);

    logic [XLEN-1:0]  q_r;
    logic [XLEN-1:0]  r_r;
    logic [XLEN-1:0]  d_r;
    logic [CNT_W-1:0] cnt;
    logic [XLEN:0]    trial;
    logic [XLEN:0]    diff;
    logic             ge;

    // Partial remainder never exceeds 2*d, so bit XLEN of diff is the borrow.
    assign trial = {r_r, q_r[XLEN-1]};
    assign diff  = trial - {1'b0, d_r};
    assign ge    = ~diff[XLEN];
    assign done  = (cnt == CNT_W'(DIV_ITERS));
    assign quot  = q_r;
    assign rem   = r_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= '0;
            r_r <= '0;
            d_r <= '0;
            cnt <= '0;
        end else if (load) begin
            q_r <= dividend;
            r_r <= '0;
            d_r <= divisor;
            cnt <= '0;
        end else if (step && !done) begin
            q_r <= {q_r[XLEN-2:0], ge};
            r_r <= ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M execute unit: 2-cycle multiplier, 34-cycle divider,
// with freeze hold, flush abort and divide special-case fast path.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic             clk,
    input logic             rst,
    ex_muldiv_unit_if.slave bus
);

    md_state_e         state;
    md_state_e         state_nxt;
    md_op_e            op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   result_q;
    logic [XLEN-1:0]   spec_res;
    logic [2*XLEN-1:0] prod_q;
    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic              mul_ph;
    logic              spec_q;
    logic              neg_q;
    logic              neg_r;

    logic              accept;
    logic              is_div;
    logic              div_sgn;
    logic              a_neg;
    logic              b_neg;
    logic              by_zero;
    logic              ovf;
    logic              sa;
    logic              sb;
    logic [XLEN-1:0]   a_abs;
    logic [XLEN-1:0]   b_abs;
    logic [XLEN-1:0]   spec_nxt;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   fix_res;
    logic              div_done;
    logic              div_load;
    logic              div_step;

    assign accept = bus.start && !bus.flush && !bus.freeze
                 && (state == S_IDLE || state == S_DONE);

    assign is_div  = bus.op[2];
    assign div_sgn = ~bus.op[0];
    assign a_neg   = div_sgn & bus.rs1[XLEN-1];
    assign b_neg   = div_sgn & bus.rs2[XLEN-1];
    assign a_abs   = a_neg ? -bus.rs1 : bus.rs1;
    assign b_abs   = b_neg ? -bus.rs2 : bus.rs2;
    assign by_zero = (bus.rs2 == '0);
    assign ovf     = div_sgn
                  && bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}
                  && bus.rs2 == '1;

    // Divide-by-zero and signed overflow skip the iterative divider.
    always_comb begin
        spec_nxt = bus.op[1] ? '0 : bus.rs1;
        if (by_zero)
            spec_nxt = bus.op[1] ? bus.rs1 : '1;
    end

    assign sa    = (op_q == OP_MULH) || (op_q == OP_MULHSU);
    assign sb    = (op_q == OP_MULH);
    assign a_ext = {{XLEN{sa & a_q[XLEN-1]}}, a_q};
    assign b_ext = {{XLEN{sb & b_q[XLEN-1]}}, b_q};

    always_comb begin
        mul_res = prod_q[2*XLEN-1:XLEN];
        if (op_q == OP_MUL)
            mul_res = prod_q[XLEN-1:0];
    end

    always_comb begin
        fix_res = neg_q ? -quot : quot;
        if (op_q[1])
            fix_res = neg_r ? -rem : rem;
        if (spec_q)
            fix_res = spec_res;
    end

    assign div_load = accept && is_div;
    assign div_step = (state == S_DIV) && !spec_q;

    muldiv_divider #(
        .XLEN(XLEN)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .load    (div_load),
        .step    (div_step),
        .dividend(a_abs),
        .divisor (b_abs),
        .quot    (quot),
        .rem     (rem),
        .done    (div_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (accept)
                    state_nxt = is_div ? S_DIV : S_MUL;
                else if (!bus.freeze)
                    state_nxt = S_IDLE;
            end
            S_MUL:   if (mul_ph) state_nxt = S_DONE;
            S_DIV:   if (spec_q || div_done) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
        if (bus.flush)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            mul_ph   <= 1'b0;
            spec_q   <= 1'b0;
            spec_res <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q     <= md_op_e'(bus.op);
                a_q      <= bus.rs1;
                b_q      <= bus.rs2;
                mul_ph   <= 1'b0;
                spec_q   <= is_div && (by_zero || ovf);
                spec_res <= spec_nxt;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
            end
            if (state == S_MUL) begin
                prod_q <= a_ext * b_ext;
                mul_ph <= 1'b1;
            end
            if (!bus.flush && state == S_MUL && mul_ph)
                result_q <= mul_res;
            if (!bus.flush && state == S_FIX)
                result_q <= fix_res;
        end
    end

    assign bus.busy   = (state == S_MUL) || (state == S_DIV)
                     || (state == S_FIX);
    assign bus.valid  = (state == S_DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed vector bench for ex_muldiv_unit: op table plus
// freeze, flush and mid-operation reset sequences.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t vt[19];

    always #5 clk = ~clk;

    ex_muldiv_unit_if #(.XLEN(32)) bus ();

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs1   = a;
        bus.rs2   = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.valid) begin
                lat = i;
                break;
            end
            if (bus.busy) bcnt++;
        end
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int lat;
        int bc;
        issue(v.op, v.a, v.b);
        wait_valid(lat, bc);
        check({nm, " latency"}, 32'(lat), 32'(v.lat));
        check({nm, " result"}, bus.result, v.exp);
        check({nm, " busy cycles"}, 32'(bc), 32'(v.lat));
        check({nm, " busy at valid"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        check({nm, " valid drop"}, 32'(bus.valid), 32'd0);
    endtask

    initial begin
        int lat;
        int bc;
        int vcnt;

        vt[0]  = '{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2};
        vt[1]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2};
        vt[2]  = '{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2};
        vt[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2};
        vt[4]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 2};
        vt[5]  = '{OP_DIV,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 34};
        vt[6]  = '{OP_REM,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 34};
        vt[7]  = '{OP_DIVU,   32'd100,      32'd7,        32'd14,       34};
        vt[8]  = '{OP_REMU,   32'd100,      32'd7,        32'd2,        34};
        vt[9]  = '{OP_DIV,    32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 34};
        vt[10] = '{OP_REM,    32'd20,       32'hFFFFFFFD, 32'd2,        34};
        vt[11] = '{OP_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34};
        vt[12] = '{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 2};
        vt[13] = '{OP_REMU,   32'd5,        32'd0,        32'd5,        2};
        vt[14] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
        vt[15] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        2};
        vt[16] = '{OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        34};
        vt[17] = '{OP_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34};
        vt[18] = '{OP_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 2};

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 3'b000;
        bus.rs1    = '0;
        bus.rs2    = '0;
        bus.freeze = 1'b0;
        bus.flush  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset valid", 32'(bus.valid), 32'd0);
        check("reset result", bus.result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 19; i++)
            run_vec($sformatf("vec%0d", i), vt[i]);

        // Freeze across DONE: result held, start ignored.
        issue(OP_MUL, 32'd7, 32'hFFFFFFFD);
        wait_valid(lat, bc);
        check("freeze mul latency", 32'(lat), 32'd2);
        bus.freeze = 1'b1;
        bus.start  = 1'b1;
        bus.op     = OP_MULHU;
        bus.rs1    = 32'hFFFFFFFF;
        bus.rs2    = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("freeze valid c%0d", i), 32'(bus.valid), 32'd1);
            check($sformatf("freeze result c%0d", i), bus.result,
                  32'hFFFFFFEB);
            check($sformatf("freeze busy c%0d", i), 32'(bus.busy), 32'd0);
        end
        bus.freeze = 1'b0;
        bus.start  = 1'b0;
        @(negedge clk);
        check("unfreeze valid", 32'(bus.valid), 32'd0);
        check("unfreeze busy", 32'(bus.busy), 32'd0);

        // Freeze while dividing does not stall iteration.
        issue(OP_DIVU, 32'd100, 32'd7);
        bus.freeze = 1'b1;
        wait_valid(lat, bc);
        check("frozen div latency", 32'(lat), 32'd34);
        check("frozen div result", bus.result, 32'd14);
        bus.freeze = 1'b0;
        @(negedge clk);
        check("frozen div drop", 32'(bus.valid), 32'd0);

        // Flush at iteration 10 together with a start.
        issue(OP_DIV, 32'hFFFFFFEC, 32'd3);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.rs1   = 32'd100;
        bus.rs2   = 32'd7;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("flush busy", 32'(bus.busy), 32'd0);
        check("flush valid", 32'(bus.valid), 32'd0);
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.valid || bus.busy) vcnt++;
        end
        check("flush no activity", 32'(vcnt), 32'd0);
        run_vec("post-flush divu", vt[7]);

        // Asynchronous reset at iteration 20.
        issue(OP_DIV, 32'hFFFFFFEC, 32'd3);
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid rst busy", 32'(bus.busy), 32'd0);
        check("mid rst valid", 32'(bus.valid), 32'd0);
        check("mid rst result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.valid) vcnt++;
        end
        check("post rst no valid", 32'(vcnt), 32'd0);
        run_vec("post-rst div", vt[5]);
        run_vec("post-rst mul", vt[0]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
